keccak_padder: RTL and testbench

// Input-side receiver of the Keccak word stream: accepts 64-bit message words
// on in/in_ready/is_last/byte_num and applies back-pressure on buffer_full.

---
 rtl/keccak_padder_if.sv | 25 ++
 rtl/keccak_padder.sv | 128 ++++++++++++
 tb/tb_keccak_padder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/keccak_padder_if.sv
// Word-stream handshake between a message driver and the SHA3-512 padder.
// Also carries the rate-block hand-off towards the permutation.
interface keccak_padder_if #(
  parameter int RATE_WORDS = 9
);
  logic [63:0]              in;
  logic                     in_ready;
  logic                     is_last;
  logic [2:0]               byte_num;
  logic                     buffer_full;
  logic [RATE_WORDS*64-1:0] out;
  logic                     out_ready;
  logic                     out_last;
  logic                     f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, out_last
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, out_last
  );
endinterface

// File: rtl/keccak_padder.sv
// Packs 64-bit message words into a 576-bit rate block and applies
// SHA-3 padding (domain byte, then 0x80 in the block's final byte).
module keccak_padder #(
  parameter int         RATE_WORDS  = 9,
  parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
  input  logic            clk,
  input  logic            reset,
  keccak_padder_if.slave  bus
);
  localparam int BW = RATE_WORDS * 64;
  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam logic [CW-1:0] LAST_C = CW'(RATE_WORDS - 1);
  localparam logic [CW-1:0] FULL_C = CW'(RATE_WORDS);

  typedef enum logic [1:0] {
    ACCEPT,
    PAD,
    FULL
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   data_q, data_d;
  logic            bf_q, bf_d;
  logic            ordy_q, ordy_d;
  logic            olast_q, olast_d;

  logic [63:0]     keep;
  logic [63:0]     dom;
  logic [63:0]     last_word;
  logic            at_last;

  // keep the first byte_num bytes; domain byte lands right after them
  assign keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> {bus.byte_num, 3'b000});
  assign dom  = {56'd0, DOMAIN_BYTE} << {3'd7 - bus.byte_num, 3'b000};
  assign at_last = (count_q == LAST_C);
  assign last_word = (bus.in & keep) | dom
                   | (at_last ? 64'h80 : 64'h0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    bf_d    = bf_q;
    ordy_d  = ordy_q;
    olast_d = olast_q;
    unique case (state_q)
      ACCEPT: begin
        if (bus.in_ready && !bf_q) begin
          count_d = count_q + 1'b1;
          bf_d    = 1'b1;
          if (bus.is_last) begin
            data_d = {data_q[BW-65:0], last_word};
            if (at_last) begin
              state_d = FULL;
              ordy_d  = 1'b1;
              olast_d = 1'b1;
            end else begin
              state_d = PAD;
            end
          end else begin
            data_d = {data_q[BW-65:0], bus.in};
            if (count_q == LAST_C) begin
              state_d = FULL;
              ordy_d  = 1'b1;
              olast_d = 1'b0;
            end else begin
              bf_d = 1'b0;
            end
          end
        end
      end
      PAD: begin
        count_d = count_q + 1'b1;
        if (at_last) begin
          data_d  = {data_q[BW-65:0], 64'h80};
          state_d = FULL;
          ordy_d  = 1'b1;
          olast_d = 1'b1;
        end else begin
          data_d = {data_q[BW-65:0], 64'h0};
        end
      end
      FULL: begin
        if (bus.f_ack && ordy_q) begin
          data_d  = '0;
          count_d = '0;
          ordy_d  = 1'b0;
          olast_d = 1'b0;
          bf_d    = 1'b0;
          state_d = ACCEPT;
        end
      end
      default: begin
        state_d = ACCEPT;
        count_d = '0;
        data_d  = '0;
        bf_d    = 1'b0;
        ordy_d  = 1'b0;
        olast_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCEPT;
      count_q <= '0;
      data_q  <= '0;
      bf_q    <= 1'b0;
      ordy_q  <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= (count_d > FULL_C) ? FULL_C : count_d;
      data_q  <= data_d;
      bf_q    <= bf_d;
      ordy_q  <= ordy_d;
      olast_q <= olast_d;
    end
  end

  assign bus.out         = data_q;
  assign bus.out_ready   = ordy_q;
  assign bus.out_last    = olast_q;
  assign bus.buffer_full = bf_q;
endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder: padding blocks, back-pressure,
// ack handling and reset during padding.
module tb_keccak_padder;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  keccak_padder_if bus ();

  keccak_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [575:0] exp_blk;
  logic [575:0] held;
  logic [63:0]  w [0:7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [575:0] obs,
                     input logic [575:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(output int cnt);
    step();
    cnt = 1;
    while (!bus.out_ready && cnt < 30) begin
      step();
      cnt++;
    end
  endtask

  task automatic ack();
    bus.f_ack = 1'b1;
    step();
    bus.f_ack = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in       = '0;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.byte_num = '0;
    bus.f_ack    = 1'b0;
    step();
    step();
    chk("rst_out", bus.out, '0);
    chk("rst_ordy", bus.out_ready, 1'b0);
    chk("rst_olast", bus.out_last, 1'b0);
    chk("rst_bf", bus.buffer_full, 1'b0);
    reset = 1'b0;
    step();

    // empty message; in_ready kept high during PAD must be ignored
    bus.in       = 64'hDEAD_BEEF_0123_4567;
    bus.in_ready = 1'b1;
    bus.is_last  = 1'b1;
    bus.byte_num = 3'd0;
    step();
    bus.is_last  = 1'b0;
    bus.in       = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("t1_bf", bus.buffer_full, 1'b1);
    n = 1;
    while (!bus.out_ready && n < 30) begin
      step();
      n++;
    end
    chk("t1_lat", n, 9);
    exp_blk = '0;
    exp_blk[575:568] = 8'h06;
    exp_blk[7:0] = 8'h80;
    chk("t1_blk", bus.out, exp_blk);
    chk("t1_last", bus.out_last, 1'b1);
    // FULL holds while in_ready is active
    step();
    step();
    chk("t5_full_out", bus.out, exp_blk);
    chk("t5_full_bf", bus.buffer_full, 1'b1);
    bus.in_ready = 1'b0;
    ack();
    chk("ack_ordy", bus.out_ready, 1'b0);
    chk("ack_out", bus.out, '0);
    chk("ack_bf", bus.buffer_full, 1'b0);
    chk("ack_last", bus.out_last, 1'b0);

    // "abc"
    bus.in       = 64'h6162_63FF_FFFF_FFFF;
    bus.in_ready = 1'b1;
    bus.is_last  = 1'b1;
    bus.byte_num = 3'd3;
    wait_ready(n);
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    exp_blk = '0;
    exp_blk[575:512] = 64'h6162_6306_0000_0000;
    exp_blk[7:0] = 8'h80;
    chk("t2_lat", n, 9);
    chk("t2_blk", bus.out, exp_blk);
    chk("t2_last", bus.out_last, 1'b1);
    ack();

    // 8 words + 7-byte final word; stray f_ack in ACCEPT is ignored
    for (int i = 0; i < 8; i++) begin
      w[i] = 64'h1000_0000_0000_0000 + 64'(i);
      bus.in = w[i];
      bus.in_ready = 1'b1;
      step();
      if (i == 3) begin
        bus.in_ready = 1'b0;
        ack();
      end
    end
    chk("t3_bf_before", bus.buffer_full, 1'b0);
    bus.in       = 64'hAABB_CCDD_EEFF_1122;
    bus.is_last  = 1'b1;
    bus.byte_num = 3'd7;
    wait_ready(n);
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    exp_blk = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7],
               64'hAABB_CCDD_EEFF_1186};
    chk("t3_lat", n, 1);
    chk("t3_blk", bus.out, exp_blk);
    chk("t3_last", bus.out_last, 1'b1);
    ack();

    // 9 full words then full padding block
    bus.in       = 64'h0101_0101_0101_0101;
    bus.in_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    bus.is_last  = 1'b1;
    bus.byte_num = 3'd0;
    bus.in       = 64'h5555_5555_5555_5555;
    chk("t4_ordy", bus.out_ready, 1'b1);
    chk("t4_last", bus.out_last, 1'b0);
    chk("t4_blk", bus.out, {9{64'h0101_0101_0101_0101}});
    held = bus.out;
    step();
    chk("t4_hold", bus.out, held);
    ack();
    chk("t4_ack_bf", bus.buffer_full, 1'b0);
    wait_ready(n);
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    exp_blk = '0;
    exp_blk[575:568] = 8'h06;
    exp_blk[7:0] = 8'h80;
    chk("t4_lat", n, 9);
    chk("t4_pad", bus.out, exp_blk);
    chk("t4_padlast", bus.out_last, 1'b1);
    ack();

    // reset in PAD, then "abc" again
    bus.in       = 64'h0;
    bus.in_ready = 1'b1;
    bus.is_last  = 1'b1;
    bus.byte_num = 3'd0;
    step();
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_out", bus.out, '0);
    chk("t6_bf", bus.buffer_full, 1'b0);
    chk("t6_ordy", bus.out_ready, 1'b0);
    bus.in       = 64'h6162_63FF_FFFF_FFFF;
    bus.in_ready = 1'b1;
    bus.is_last  = 1'b1;
    bus.byte_num = 3'd3;
    wait_ready(n);
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    exp_blk = '0;
    exp_blk[575:512] = 64'h6162_6306_0000_0000;
    exp_blk[7:0] = 8'h80;
    chk("t6_lat", n, 9);
    chk("t6_blk", bus.out, exp_blk);
    chk("t6_last", bus.out_last, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
